// File: rtl/r4_butter_stream.sv
// Streaming radix-4 DIT butterfly: captures one complex input set, then emits X0..X3
// serially over a valid/ready handshake with W+2 bit full-precision results.
module r4_butter_stream #(
  parameter int W = 8
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic signed [W-1:0] xr0,
  input  logic signed [W-1:0] xi0,
  input  logic signed [W-1:0] xr1,
  input  logic signed [W-1:0] xi1,
  input  logic signed [W-1:0] xr2,
  input  logic signed [W-1:0] xi2,
  input  logic signed [W-1:0] xr3,
  input  logic signed [W-1:0] xi3,
  input  logic                inv,
  input  logic                scale,
  input  logic                in_valid,
  output logic                in_ready,
  output logic signed [W+1:0] Xr,
  output logic signed [W+1:0] Xi,
  output logic [1:0]          out_idx,
  output logic                out_last,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int E = W + 2;

  logic signed [W-1:0] hr0, hi0, hr1, hi1, hr2, hi2, hr3, hi3;
  logic                inv_q, scale_q, busy;
  logic [1:0]          idx;
  logic                accept, beat_take;

  function automatic logic signed [E-1:0] sx(input logic signed [W-1:0] v);
    return {{2{v[W-1]}}, v};
  endfunction

  // Handshake: a transfer happens on an edge where valid and ready are both high;
  // valid never waits on ready, and in_ready reopens during the final beat so
  // a new set can be accepted without an idle cycle.
  assign beat_take = busy & out_ready;
  assign in_ready  = ~busy | (beat_take & (idx == 2'd3));
  assign accept    = in_valid & in_ready;
  assign out_valid = busy;
  assign out_idx   = idx;
  assign out_last  = busy & (idx == 2'd3);

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      hr0 <= '0; hi0 <= '0; hr1 <= '0; hi1 <= '0;
      hr2 <= '0; hi2 <= '0; hr3 <= '0; hi3 <= '0;
      inv_q   <= 1'b0;
      scale_q <= 1'b0;
      busy    <= 1'b0;
      idx     <= 2'd0;
    end else if (accept) begin
      hr0 <= xr0; hi0 <= xi0; hr1 <= xr1; hi1 <= xi1;
      hr2 <= xr2; hi2 <= xi2; hr3 <= xr3; hi3 <= xi3;
      inv_q   <= inv;
      scale_q <= scale;
      busy    <= 1'b1;
      idx     <= 2'd0;
    end else if (beat_take) begin
      if (idx == 2'd3) busy <= 1'b0;
      idx <= idx + 2'd1;
    end
  end

  logic signed [E-1:0] a0r, a0i, a1r, a1i, a2r, a2i, a3r, a3i;
  logic signed [E-1:0] sum_r, sum_i;
  logic [1:0]          sel;

  always_comb begin
    a0r = sx(hr0); a0i = sx(hi0);
    a1r = sx(hr1); a1i = sx(hi1);
    a2r = sx(hr2); a2i = sx(hi2);
    a3r = sx(hr3); a3i = sx(hi3);
    // The inverse transform only exchanges the X1 and X3 equations.
    sel = (inv_q && idx[0]) ? (idx ^ 2'd2) : idx;
    sum_r = '0;
    sum_i = '0;
    case (sel)
      2'd0: begin
        sum_r = a0r + a1r + a2r + a3r;
        sum_i = a0i + a1i + a2i + a3i;
      end
      2'd1: begin
        sum_r = a0r + a1i - a2r - a3i;
        sum_i = a0i - a1r - a2i + a3r;
      end
      2'd2: begin
        sum_r = a0r - a1r + a2r - a3r;
        sum_i = a0i - a1i + a2i - a3i;
      end
      default: begin
        sum_r = a0r - a1i - a2r + a3i;
        sum_i = a0i + a1r - a2i - a3r;
      end
    endcase
    Xr = scale_q ? (sum_r >>> 2) : sum_r;
    Xi = scale_q ? (sum_i >>> 2) : sum_i;
  end

endmodule

// File: tb/tb_r4_butter_stream.sv
// Bench for r4_butter_stream (W = 8): directed cases plus a randomized stream
// checked against a DFT-by-rotation reference model.
module tb_r4_butter_stream;

  logic              CLOCK = 1'b0;
  logic              RESET;
  logic signed [7:0] xr0, xi0, xr1, xi1, xr2, xi2, xr3, xi3;
  logic              inv, scale, in_valid, in_ready, out_ready;
  logic signed [9:0] Xr, Xi;
  logic [1:0]        out_idx;
  logic              out_last, out_valid;

  int  checks = 0;
  int  errors = 0;
  int  cr[4], ci[4];
  int  er[4], ei[4];
  bit  c_inv, c_sc;
  logic [21:0] exp_q[$];
  logic [21:0] got;

  assign xr0 = cr[0][7:0]; assign xi0 = ci[0][7:0];
  assign xr1 = cr[1][7:0]; assign xi1 = ci[1][7:0];
  assign xr2 = cr[2][7:0]; assign xi2 = ci[2][7:0];
  assign xr3 = cr[3][7:0]; assign xi3 = ci[3][7:0];
  assign inv   = c_inv;
  assign scale = c_sc;

  r4_butter_stream #(.W(8)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .xr0(xr0), .xi0(xi0), .xr1(xr1), .xi1(xi1),
    .xr2(xr2), .xi2(xi2), .xr3(xr3), .xi3(xi3),
    .inv(inv), .scale(scale), .in_valid(in_valid), .in_ready(in_ready),
    .Xr(Xr), .Xi(Xi), .out_idx(out_idx), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // X_k = sum_n x_n * w^(n*k), w = -j forward, +j inverse; rotation by +-j done on pairs.
  function automatic void model();
    int sr, si, a, b, t;
    for (int k = 0; k < 4; k++) begin
      sr = 0; si = 0;
      for (int n = 0; n < 4; n++) begin
        a = cr[n]; b = ci[n];
        for (int m = 0; m < (n * k) % 4; m++) begin
          t = a;
          if (!c_inv) begin a = b;  b = -t; end
          else        begin a = -b; b = t;  end
        end
        sr += a; si += b;
      end
      er[k] = c_sc ? (sr >>> 2) : sr;
      ei[k] = c_sc ? (si >>> 2) : si;
    end
  endfunction

  task automatic load_set(input int r0, r1, r2, r3, i0, i1, i2, i3, input bit iv, input bit sc);
    cr[0] = r0; cr[1] = r1; cr[2] = r2; cr[3] = r3;
    ci[0] = i0; ci[1] = i1; ci[2] = i2; ci[3] = i3;
    c_inv = iv; c_sc = sc;
    model();
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid"}, int'(out_valid), 0);
    chk({tag, "_ready"}, int'(in_ready), 1);
    chk({tag, "_last"},  int'(out_last), 0);
  endtask

  task automatic check_beat(input string tag, input int k, input bit exp_rdy);
    chk({tag, "_valid"}, int'(out_valid), 1);
    chk({tag, "_idx"},   int'(out_idx), k);
    chk({tag, "_xr"},    int'(Xr), er[k]);
    chk({tag, "_xi"},    int'(Xi), ei[k]);
    chk({tag, "_last"},  int'(out_last), (k == 3) ? 1 : 0);
    chk({tag, "_inrdy"}, int'(in_ready), exp_rdy ? 1 : 0);
  endtask

  // Accept the loaded set from idle, then drain all four beats with out_ready high.
  task automatic run_set(input string tag);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    chk({tag, "_accept_rdy"}, int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_beat(tag, k, k == 3);
      tick();
    end
    check_idle({tag, "_end"});
  endtask

  task automatic random_step();
    out_ready = ($urandom_range(0, 3) != 0);
    in_valid  = ($urandom_range(0, 1) == 1);
    for (int n = 0; n < 4; n++) begin
      cr[n] = $urandom_range(0, 255) - 128;
      ci[n] = $urandom_range(0, 255) - 128;
    end
    c_inv = 1'($urandom_range(0, 1));
    c_sc  = 1'($urandom_range(0, 1));
    #1;
    if (out_valid && out_ready) begin
      chk("rnd_underflow", (exp_q.size() > 0) ? 1 : 0, 1);
      if (exp_q.size() > 0) begin
        got = exp_q.pop_front();
        chk("rnd_beat", int'({out_idx, Xr, Xi}), int'(got));
        chk("rnd_last", int'(out_last), (out_idx == 2'd3) ? 1 : 0);
      end
    end
    if (in_valid && in_ready) begin
      model();
      for (int k = 0; k < 4; k++) exp_q.push_back({2'(k), 10'(er[k]), 10'(ei[k])});
    end
    @(posedge CLOCK);
    #1;
  endtask

  initial begin
    RESET = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    load_set(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    tick(); tick();
    check_idle("reset");
    chk("reset_xr", int'(Xr), 0);
    chk("reset_xi", int'(Xi), 0);
    chk("reset_idx", int'(out_idx), 0);
    RESET = 1'b1;
    tick();
    check_idle("post_reset");

    load_set(1, 2, 3, 4, 0, 0, 0, 0, 1'b0, 1'b0);
    run_set("fwd_1234");
    load_set(1, 2, 3, 4, 0, 0, 0, 0, 1'b1, 1'b0);
    run_set("inv_1234");
    load_set(127, -128, 127, -128, 0, 0, 0, 0, 1'b0, 1'b0);
    run_set("growth");
    chk("growth_x2r_const", er[2], 510);
    load_set(127, -128, 127, -128, 0, 0, 0, 0, 1'b0, 1'b1);
    run_set("growth_scaled");
    load_set(1, 2, 3, 4, 0, 0, 0, 0, 1'b0, 1'b1);
    run_set("scale_1234");
    load_set(-128, 127, -128, -1, 127, -128, 5, -7, 1'b1, 1'b0);
    run_set("mixed_inv");

    // Backpressure at X1 with a competing input set that must be ignored.
    load_set(9, -3, 20, 7, -4, 11, 0, -60, 1'b0, 1'b0);
    out_ready = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_beat("bp", 0, 1'b0);
    tick();
    check_beat("bp", 1, 1'b0);
    out_ready = 1'b0;
    cr[0] = 100; cr[1] = -100; ci[2] = 33;
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_beat("bp_hold", 1, 1'b0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check_beat("bp", 2, 1'b0);
    tick();
    check_beat("bp", 3, 1'b1);
    tick();
    check_idle("bp_end");

    // Back-to-back: set B accepted during A's last beat.
    load_set(3, 1, -4, 1, 5, -9, 2, 6, 1'b0, 1'b0);
    out_ready = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_beat("b2b_a", k, k == 3);
      if (k < 3) tick();
    end
    load_set(-50, 60, 70, -80, 10, 20, -30, 40, 1'b1, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_beat("b2b_b", k, k == 3);
      tick();
    end
    check_idle("b2b_end");

    // Reset in the middle of a burst.
    load_set(12, -34, 56, -78, 90, -11, 22, -33, 1'b0, 1'b0);
    out_ready = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_beat("rst_mid", 0, 1'b0);
    tick();
    tick();
    check_beat("rst_mid", 2, 1'b0);
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    check_idle("rst_mid_after");
    chk("rst_mid_xr", int'(Xr), 0);
    chk("rst_mid_xi", int'(Xi), 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("rst_mid_no_beats", int'(out_valid), 0);
    end

    // Randomized stream with random backpressure against the queued model results.
    for (int c = 0; c < 400; c++) random_step();
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      if (out_valid) begin
        got = exp_q.pop_front();
        chk("drain_beat", int'({out_idx, Xr, Xi}), int'(got));
      end
      @(posedge CLOCK);
      #1;
    end
    chk("drain_empty", exp_q.size(), 0);
    check_idle("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
